alu_uart_if: RTL and testbench
==============================

# alu_uart_if

Frame controller between the UART and `alu_mod`.
- Collects a three-byte command from the UART receiver (operand 1, operand 2, opcode) and drives the ALU operand and opcode inputs from registers.
- Waits for the ALU result, then hands the result byte to the UART transmitter with a start/done handshake.
- Sits directly upstream of `alu_mod`, replacing the switch/button loading used in board bring-up, and downstream of the UART RX.

## Interface
- `NB_DATA`, 8: operand/result width, equal to the UART byte width.
- `NB_OP`, 6: opcode width. The opcode is taken from the low `NB_OP` bits of the third byte; the upper bits are ignored.
- `ALU_LAT`, 1: ALU result latency in clocks (0 = combinational, 1 = registered output).
- `TIMEOUT_CYC`, 100000: maximum idle clocks allowed between bytes of one frame; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_rx_data`  in  NB_DATA  received byte, valid while `i_rx_done` is high.
- `i_rx_done`  in  1  one-cycle strobe, byte received.
- `o_ope1`  out  NB_DATA  to ALU `i_ope1`.
- `o_ope2`  out  NB_DATA  to ALU `i_ope2`.
- `o_opcode`  out  NB_OP  to ALU `i_opcode`.
- `i_alu_result`  in  NB_DATA  from ALU `o_result`.
- `o_tx_data`  out  NB_DATA  byte to transmit.
- `o_tx_start`  out  1  one-cycle strobe, start transmission.
- `i_tx_done`  in  1  one-cycle strobe, transmitter finished the byte.
- `o_busy`  out  1  high in EXEC, SEND and WAIT_TX.
- `o_overrun`  out  1  sticky; set when an RX byte is dropped, cleared only by reset.
- `o_timeout`  out  1  one-cycle pulse when a partial frame is abandoned.

## Operation
- States: IDLE, GET_OPE2, GET_OP, EXEC, SEND, WAIT_TX. Reset state is IDLE.
- Reset values: every output is 0, the timeout counter is 0 and the EXEC counter is 0.
- IDLE:
  - `i_rx_done` loads `o_ope1` and moves to GET_OPE2.
- GET_OPE2:
  - `i_rx_done` loads `o_ope2` and moves to GET_OP.
- GET_OP:
  - `i_rx_done` loads `o_opcode` from `i_rx_data[NB_OP-1:0]` and moves to EXEC.
- EXEC:
  - Counts `ALU_LAT`+1 cycles.
  - On the last cycle, registers `i_alu_result` into `o_tx_data` and moves to SEND.
- SEND:
  - Holds `o_tx_start` high for exactly one cycle, then moves to WAIT_TX.
- WAIT_TX:
  - `i_tx_done` moves to IDLE.
- Operand and opcode registers hold their values until overwritten by the next frame; they are not cleared on timeout or frame end.
- Timeout, in GET_OPE2 and GET_OP only:
  - The counter clears on every accepted byte and increments every cycle otherwise.
  - When the count reaches `TIMEOUT_CYC` with no `i_rx_done`, the block goes to IDLE and pulses `o_timeout`.
  - `i_rx_done` in the same cycle the count reaches `TIMEOUT_CYC`: the byte is accepted and no timeout occurs.
- Dropped bytes:
  - `i_rx_done` in EXEC, SEND or WAIT_TX is dropped and sets `o_overrun`.
  - This includes the cycle in which `i_tx_done` arrives.
- A stray `i_tx_done` outside WAIT_TX is ignored.
- Asserting `rst` mid-frame or mid-transmission forces IDLE and all reset values immediately. Any in-flight TX is the transmitter's concern.

## Timing
- Byte strobe in cycle n: the corresponding register is updated and visible in cycle n+1.
- Opcode strobe in cycle m:
  - ALU inputs are stable from cycle m+1.
  - `o_tx_data` is valid and `o_tx_start` is high in cycle m+2+`ALU_LAT`.
  - With the default parameters, `o_tx_start` is high in cycle m+3.
- `o_busy` rises in cycle m+1 and falls in the cycle after `i_tx_done`.
- `o_tx_data` is held stable from `o_tx_start` until the next frame's result is captured.
- Back-to-back: a byte strobe in the cycle immediately after returning to IDLE is accepted as the next `o_ope1`.

## Test plan
- Reset: hold `rst`=0 for 5 cycles -> all outputs 0 and state IDLE. Release, then send 0xF1, 0xFF, 0x20 (ADD) against `alu_mod` -> `o_ope1`=0xF1, `o_ope2`=0xFF, `o_opcode`=0x20, `o_tx_data`=0xF0, and `o_tx_start` exactly 3 cycles after the opcode strobe.
- Opcode sweep with operands 0xF1/0xFF:
  - 0x22 SUB -> 0xF2; 0x24 AND -> 0xF1; 0x25 OR -> 0xFF; 0x26 XOR -> 0x0E; 0x27 NOR -> 0x00.
  - Byte 0xE4 -> `o_opcode`=0x24 (upper bits ignored).
- Handshake: delay `i_tx_done` 50 cycles after `o_tx_start` -> `o_busy` stays high throughout and `o_tx_start` pulses only once. Inject `i_rx_done` during WAIT_TX -> byte dropped and `o_overrun`=1, staying 1 until reset.
- Timeout with `TIMEOUT_CYC`=20: send one byte then wait 20 cycles -> one-cycle `o_timeout` and return to IDLE. Send the second byte exactly at count 20 -> accepted, no timeout.
- Reset mid-frame: assert `rst` after two bytes -> all outputs 0 immediately. A fresh 3-byte frame then completes normally.
- `ALU_LAT`=0 with a combinational ALU model -> `o_tx_start` 2 cycles after the opcode strobe, carrying the correct result.

Source files
------------

// File: rtl/alu_uart_if.sv
// -----------------------------------------------------------------------------
// alu_uart_if
//
// Frame controller between a UART and alu_mod. Three received bytes form one
// command: operand 1, operand 2, opcode (low NB_OP bits of the third byte).
// The operand/opcode registers drive the ALU directly. After ALU_LAT+1 cycles
// the ALU result is captured and handed to the UART transmitter with a
// one-cycle start strobe, then the block waits for the transmitter's done
// strobe before accepting the next frame.
//
// Parameters
//   NB_DATA      operand/result width (equals the UART byte width)
//   NB_OP        opcode width
//   ALU_LAT      ALU result latency in clocks (0 = combinational ALU)
//   TIMEOUT_CYC  max idle clocks between bytes of a frame (0 = no timeout)
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous, active-low reset
//   i_rx_data     received byte, valid while i_rx_done is high
//   i_rx_done     one-cycle strobe, byte received
//   o_ope1        operand 1 to ALU
//   o_ope2        operand 2 to ALU
//   o_opcode      opcode to ALU
//   i_alu_result  result from ALU
//   o_tx_data     byte to transmit, held until the next result is captured
//   o_tx_start    one-cycle strobe, start transmission
//   i_tx_done     one-cycle strobe, transmitter finished the byte
//   o_busy        high in EXEC, SEND and WAIT_TX
//   o_overrun     sticky, a received byte was dropped; cleared only by reset
//   o_timeout     one-cycle pulse when a partial frame is abandoned
//   o_state       current FSM state (debug/observation)
//
// Handshakes: i_rx_done and i_tx_done are single-cycle strobes with no
// back-pressure; a byte strobe that arrives while the block cannot take it is
// dropped and recorded in o_overrun. o_tx_start is a single-cycle strobe and
// o_tx_data is valid from that cycle onward.
// -----------------------------------------------------------------------------
module alu_uart_if #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int ALU_LAT     = 1,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_DATA-1:0] o_ope1,
    output logic [NB_DATA-1:0] o_ope2,
    output logic [NB_OP-1:0]   o_opcode,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_overrun,
    output logic               o_timeout,
    output logic [2:0]         o_state
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] GET_OPE2 = 3'd1;
    localparam logic [2:0] GET_OP   = 3'd2;
    localparam logic [2:0] EXEC     = 3'd3;
    localparam logic [2:0] SEND     = 3'd4;
    localparam logic [2:0] WAIT_TX  = 3'd5;

    // Counter widths are kept at least one bit so the degenerate parameter
    // values (TIMEOUT_CYC = 0, ALU_LAT = 0) still elaborate.
    localparam int              TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYC);
    localparam logic            TO_EN   = (TIMEOUT_CYC != 0);
    localparam int              EX_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;
    localparam logic [EX_W-1:0] EX_LAST = EX_W'(ALU_LAT);

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [EX_W-1:0] exec_cnt;
    logic            in_frame;
    logic            in_busy;
    logic            to_hit;
    logic            exec_last;

    assign in_frame  = (state == GET_OPE2) || (state == GET_OP);
    assign in_busy   = (state == EXEC) || (state == SEND) || (state == WAIT_TX);
    // A byte arriving in the same cycle the limit is reached wins over the
    // timeout, so to_hit alone never abandons a frame; see the FSM below.
    assign to_hit    = TO_EN && (to_cnt == TO_MAX);
    assign exec_last = (exec_cnt == EX_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_rx_done) state_nxt = GET_OPE2;
            end
            GET_OPE2: begin
                if (i_rx_done)   state_nxt = GET_OP;
                else if (to_hit) state_nxt = IDLE;
            end
            GET_OP: begin
                if (i_rx_done)   state_nxt = EXEC;
                else if (to_hit) state_nxt = IDLE;
            end
            EXEC: begin
                if (exec_last) state_nxt = SEND;
            end
            SEND: begin
                state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Inter-byte timeout counter: only runs while a frame is partially
    // received, restarts on every accepted byte.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (!TO_EN || !in_frame || i_rx_done || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= in_frame && to_hit && !i_rx_done;
        end
    end

    // ------------------------------------------------------------------
    // EXEC dwell counter: ALU_LAT+1 cycles, the last of which samples the
    // ALU result. Entry into EXEC always sees the counter at zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exec_cnt <= '0;
        end else if ((state == EXEC) && !exec_last) begin
            exec_cnt <= exec_cnt + EX_W'(1);
        end else begin
            exec_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Operand / opcode registers. They are only overwritten by the next
    // frame's bytes, never cleared by timeout or frame completion.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_ope1   <= '0;
            o_ope2   <= '0;
            o_opcode <= '0;
        end else if (i_rx_done) begin
            case (state)
                IDLE:     o_ope1   <= i_rx_data;
                GET_OPE2: o_ope2   <= i_rx_data;
                GET_OP:   o_opcode <= i_rx_data[NB_OP-1:0];
                default:  ;
            endcase
        end
    end

    // Result register: stays stable through SEND/WAIT_TX and until the next
    // frame's result is sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_tx_data <= '0;
        end else if ((state == EXEC) && exec_last) begin
            o_tx_data <= i_alu_result;
        end
    end

    // Any byte strobe while busy is lost, including one coinciding with
    // i_tx_done (the FSM is still in WAIT_TX in that cycle).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_overrun <= 1'b0;
        end else if (i_rx_done && in_busy) begin
            o_overrun <= 1'b1;
        end
    end

    // SEND lasts exactly one cycle, so decoding it gives a single-cycle
    // start strobe straight from the state register.
    assign o_tx_start = (state == SEND);
    assign o_busy     = in_busy;
    assign o_state    = state;

endmodule

// File: tb/tb_alu_uart_if.sv
// -----------------------------------------------------------------------------
// tb_alu_uart_if
//
// Directed bench for alu_uart_if. dut0 runs with a registered ALU model
// (ALU_LAT=1) and a short timeout (20 cycles); dut1 runs with a combinational
// ALU model (ALU_LAT=0). Expected result bytes are queued when an opcode byte
// is driven and compared when the DUT raises o_tx_start.
// -----------------------------------------------------------------------------
module tb_alu_uart_if;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_OPE2 = 3'd1;
    localparam logic [2:0] S_GET_OP   = 3'd2;
    localparam logic [2:0] S_WAIT_TX  = 3'd5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- dut0 signals ----------------
    logic [7:0] rx_data0 = '0;
    logic       rx_done0 = 1'b0;
    logic       tx_done0 = 1'b0;
    logic [7:0] ope1_0, ope2_0, tx_data0, alu_res0;
    logic [5:0] opcode0;
    logic       tx_start0, busy0, overrun0, timeout0;
    logic [2:0] state0;

    // ---------------- dut1 signals ----------------
    logic [7:0] rx_data1 = '0;
    logic       rx_done1 = 1'b0;
    logic       tx_done1 = 1'b0;
    logic [7:0] ope1_1, ope2_1, tx_data1, alu_res1;
    logic [5:0] opcode1;
    logic       tx_start1, busy1, overrun1, timeout1;
    logic [2:0] state1;

    // ---------------- ALU reference behaviour ----------------
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b;
            6'h03:   return 8'($signed(a) >>> b);
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) alu_res0 <= alu_f(ope1_0, ope2_0, opcode0);
    assign alu_res1 = alu_f(ope1_1, ope2_1, opcode1);

    alu_uart_if #(.NB_DATA(8), .NB_OP(6), .ALU_LAT(1), .TIMEOUT_CYC(20)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .i_rx_data    (rx_data0),
        .i_rx_done    (rx_done0),
        .o_ope1       (ope1_0),
        .o_ope2       (ope2_0),
        .o_opcode     (opcode0),
        .i_alu_result (alu_res0),
        .o_tx_data    (tx_data0),
        .o_tx_start   (tx_start0),
        .i_tx_done    (tx_done0),
        .o_busy       (busy0),
        .o_overrun    (overrun0),
        .o_timeout    (timeout0),
        .o_state      (state0)
    );

    alu_uart_if #(.NB_DATA(8), .NB_OP(6), .ALU_LAT(0)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .i_rx_data    (rx_data1),
        .i_rx_done    (rx_done1),
        .o_ope1       (ope1_1),
        .o_ope2       (ope2_1),
        .o_opcode     (opcode1),
        .i_alu_result (alu_res1),
        .o_tx_data    (tx_data1),
        .o_tx_start   (tx_start1),
        .i_tx_done    (tx_done1),
        .o_busy       (busy1),
        .o_overrun    (overrun1),
        .o_timeout    (timeout1),
        .o_state      (state1)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int op_cyc0 = 0;
    int op_cyc1 = 0;
    int start_cnt0 = 0;
    int start_cnt1 = 0;
    int to_cnt0 = 0;
    int chk_cnt = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst && tx_start0) begin
            start_cnt0++;
            if (exp_q0.size() == 0) begin
                chk("tx0_spurious_start", 32'd1, 32'd0);
            end else begin
                e = exp_q0.pop_front();
                chk("tx0_data", {24'd0, tx_data0}, {24'd0, e});
                chk("tx0_latency", cyc - op_cyc0, 32'd3);
            end
        end
        if (rst && tx_start1) begin
            start_cnt1++;
            if (exp_q1.size() == 0) begin
                chk("tx1_spurious_start", 32'd1, 32'd0);
            end else begin
                e = exp_q1.pop_front();
                chk("tx1_data", {24'd0, tx_data1}, {24'd0, e});
                chk("tx1_latency", cyc - op_cyc1, 32'd2);
            end
        end
        if (timeout0) to_cnt0++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int which, input logic [7:0] b);
        if (which == 0) begin
            rx_data0 = b;
            rx_done0 = 1'b1;
        end else begin
            rx_data1 = b;
            rx_done1 = 1'b1;
        end
        tick();
        rx_done0 = 1'b0;
        rx_done1 = 1'b0;
    endtask

    task automatic send_op(input int which, input logic [7:0] op, input logic [7:0] e);
        if (which == 0) begin
            exp_q0.push_back(e);
            op_cyc0 = cyc;
        end else begin
            exp_q1.push_back(e);
            op_cyc1 = cyc;
        end
        send_byte(which, op);
    endtask

    task automatic send_frame(input int which, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] op, input logic [7:0] e);
        send_byte(which, a);
        send_byte(which, b);
        send_op(which, op, e);
    endtask

    // Waits (bounded) for o_tx_start; returns on the falling edge it was seen.
    task automatic wait_start(input int which);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = (which == 0) ? tx_start0 : tx_start1;
        end
        chk(which == 0 ? "tx0_start_seen" : "tx1_start_seen", {31'd0, found}, 32'd1);
    endtask

    task automatic finish_tx(input int which, input int dly);
        repeat (dly) tick();
        if (which == 0) tx_done0 = 1'b1;
        else            tx_done1 = 1'b1;
        tick();
        tx_done0 = 1'b0;
        tx_done1 = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish, checks %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    logic [7:0] sweep_op  [6] = '{8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'hE4};
    logic [7:0] sweep_exp [6] = '{8'hF2, 8'hF1, 8'hFF, 8'h0E, 8'h00, 8'hF1};

    initial begin
        int  sc;
        logic busy_ok;

        // Reset held for 5 cycles.
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_ope1",     {24'd0, ope1_0},   32'h00);
        chk("rst_ope2",     {24'd0, ope2_0},   32'h00);
        chk("rst_opcode",   {26'd0, opcode0},  32'h00);
        chk("rst_tx_data",  {24'd0, tx_data0}, 32'h00);
        chk("rst_tx_start", {31'd0, tx_start0}, 32'd0);
        chk("rst_busy",     {31'd0, busy0},    32'd0);
        chk("rst_overrun",  {31'd0, overrun0}, 32'd0);
        chk("rst_timeout",  {31'd0, timeout0}, 32'd0);
        chk("rst_state",    {29'd0, state0},   {29'd0, S_IDLE});
        chk("rst_state1",   {29'd0, state1},   {29'd0, S_IDLE});
        rst = 1'b1;
        tick();

        // First frame: ADD.
        send_frame(0, 8'hF1, 8'hFF, 8'h20, 8'hF0);
        chk("add_ope1",   {24'd0, ope1_0},  32'hF1);
        chk("add_ope2",   {24'd0, ope2_0},  32'hFF);
        chk("add_opcode", {26'd0, opcode0}, 32'h20);
        chk("add_busy",   {31'd0, busy0},   32'd1);
        wait_start(0);
        finish_tx(0, 2);
        chk("add_busy_fall", {31'd0, busy0},  32'd0);
        chk("add_idle",      {29'd0, state0}, {29'd0, S_IDLE});

        // Opcode sweep, including one with upper bits set in the opcode byte.
        for (int i = 0; i < 6; i++) begin
            send_frame(0, 8'hF1, 8'hFF, sweep_op[i], sweep_exp[i]);
            chk("sweep_opcode", {26'd0, opcode0}, {26'd0, sweep_op[i][5:0]});
            wait_start(0);
            finish_tx(0, 1);
        end

        // Stray i_tx_done in IDLE is ignored.
        finish_tx(0, 1);
        chk("stray_txdone_state", {29'd0, state0}, {29'd0, S_IDLE});

        // Long transmit handshake with a byte injected during WAIT_TX.
        sc = start_cnt0;
        send_frame(0, 8'hF1, 8'hFF, 8'h20, 8'hF0);
        wait_start(0);
        busy_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rx_data0 = 8'h55;
            rx_done0 = (i == 10);
            tick();
            if (!busy0 || state0 !== S_WAIT_TX) busy_ok = 1'b0;
        end
        rx_done0 = 1'b0;
        chk("hs_busy_held",  {31'd0, busy_ok},  32'd1);
        chk("hs_one_start",  start_cnt0 - sc,   32'd1);
        chk("hs_overrun",    {31'd0, overrun0}, 32'd1);
        chk("hs_drop_ope1",  {24'd0, ope1_0},   32'hF1);
        finish_tx(0, 0);
        chk("hs_idle", {29'd0, state0}, {29'd0, S_IDLE});

        // Byte coinciding with i_tx_done is dropped; the next cycle's byte starts a frame.
        send_frame(0, 8'hF1, 8'hFF, 8'h25, 8'hFF);
        wait_start(0);
        tick();
        rx_data0 = 8'h77;
        rx_done0 = 1'b1;
        tx_done0 = 1'b1;
        tick();
        tx_done0 = 1'b0;
        rx_data0 = 8'h12;
        tick();
        rx_done0 = 1'b0;
        chk("b2b_ope1",  {24'd0, ope1_0}, 32'h12);
        chk("b2b_state", {29'd0, state0}, {29'd0, S_GET_OPE2});
        send_byte(0, 8'h34);
        send_op(0, 8'h20, 8'h46);
        wait_start(0);
        finish_tx(0, 1);
        chk("overrun_sticky", {31'd0, overrun0}, 32'd1);

        // Timeout: one byte, then 20 idle cycles.
        send_byte(0, 8'h10);
        repeat (20) tick();
        chk("to_not_yet",  {29'd0, state0},   {29'd0, S_GET_OPE2});
        chk("to_no_pulse", {31'd0, timeout0}, 32'd0);
        tick();
        chk("to_idle",     {29'd0, state0},   {29'd0, S_IDLE});
        chk("to_pulse",    {31'd0, timeout0}, 32'd1);
        chk("to_keep_ope1", {24'd0, ope1_0},  32'h10);
        tick();
        chk("to_pulse_end", {31'd0, timeout0}, 32'd0);

        // Second byte exactly at the limit is accepted.
        send_byte(0, 8'h10);
        repeat (20) tick();
        send_byte(0, 8'h20);
        chk("to_edge_state", {29'd0, state0}, {29'd0, S_GET_OP});
        chk("to_edge_ope2",  {24'd0, ope2_0}, 32'h20);
        send_op(0, 8'h20, 8'h30);
        wait_start(0);
        finish_tx(0, 1);
        chk("to_pulse_count", to_cnt0, 32'd1);

        // Reset mid-frame.
        send_byte(0, 8'hAA);
        send_byte(0, 8'hBB);
        rst = 1'b0;
        #1;
        chk("mrst_ope1",    {24'd0, ope1_0},   32'h00);
        chk("mrst_ope2",    {24'd0, ope2_0},   32'h00);
        chk("mrst_opcode",  {26'd0, opcode0},  32'h00);
        chk("mrst_tx_data", {24'd0, tx_data0}, 32'h00);
        chk("mrst_overrun", {31'd0, overrun0}, 32'd0);
        chk("mrst_state",   {29'd0, state0},   {29'd0, S_IDLE});
        tick();
        rst = 1'b1;
        send_frame(0, 8'h05, 8'h03, 8'h22, 8'h02);
        wait_start(0);
        finish_tx(0, 1);

        // Combinational ALU instance.
        send_frame(1, 8'hF1, 8'hFF, 8'h26, 8'h0E);
        wait_start(1);
        finish_tx(1, 1);
        send_frame(1, 8'h81, 8'h01, 8'h03, 8'hC0);
        wait_start(1);
        finish_tx(1, 1);
        chk("lat0_busy_fall", {31'd0, busy1}, 32'd0);

        tick();
        chk("q0_drained", exp_q0.size(), 32'd0);
        chk("q1_drained", exp_q1.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
